// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Optional macro ALU_SHARE_OPCHECK_EN: opcodes 6-15 are rejected locally without issuing to the ALU.
`timescale 1ns/1ps
module alu_share_arbiter #(
  parameter int Width    = 8,
  parameter int Priority = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [Width-1:0]   req0_A,
  input  logic [Width-1:0]   req0_B,
  input  logic [3:0]         req0_OP,
  input  logic               req0_Cin,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [Width-1:0]   req1_A,
  input  logic [Width-1:0]   req1_B,
  input  logic [3:0]         req1_OP,
  input  logic               req1_Cin,
  output logic [Width-1:0]   alu_A,
  output logic [Width-1:0]   alu_B,
  output logic [3:0]         alu_OP,
  output logic               alu_Cin,
  input  logic [2*Width-1:0] alu_Out,
  input  logic               alu_Oddparitty,
  input  logic               alu_Invalid,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*Width-1:0] rsp_Out,
  output logic               rsp_Oddparitty,
  output logic               rsp_Invalid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_ptr;
  logic [Width-1:0]   r_alu_a;
  logic [Width-1:0]   r_alu_b;
  logic [3:0]         r_alu_op;
  logic               r_alu_cin;
  logic               r_rsp_valid;
  logic               r_rsp_id;
  logic [2*Width-1:0] r_rsp_out;
  logic               r_rsp_odd;
  logic               r_rsp_inv;

  logic               w_contested;
  logic               w_grant;
  logic               w_accept;
  logic               w_illegal;
  logic               w_issue;
  logic [Width-1:0]   w_sel_a;
  logic [Width-1:0]   w_sel_b;
  logic [3:0]         w_sel_op;
  logic               w_sel_cin;

  // Uncontested: req1 wins only when it is the sole valid requester.
  assign w_contested = req0_valid & req1_valid;
  assign w_grant     = w_contested ? r_ptr : req1_valid;

  // Ready is gated by rst_n because the async reset forces IDLE while held.
  assign req0_ready = rst_n && (r_state == S_IDLE) && req0_valid && !w_grant;
  assign req1_ready = rst_n && (r_state == S_IDLE) && req1_valid &&  w_grant;
  assign w_accept   = req0_ready | req1_ready;

  assign w_sel_a   = w_grant ? req1_A   : req0_A;
  assign w_sel_b   = w_grant ? req1_B   : req0_B;
  assign w_sel_op  = w_grant ? req1_OP  : req0_OP;
  assign w_sel_cin = w_grant ? req1_Cin : req0_Cin;

`ifdef ALU_SHARE_OPCHECK_EN
  assign w_illegal = w_sel_op[3] | (w_sel_op[2:1] == 2'b11);
`else
  assign w_illegal = 1'b0;
`endif
  assign w_issue = w_accept & ~w_illegal;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: default assigned first so no path through the case can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_illegal ? S_RESP : S_EXEC;
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= 1'(Priority);
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_alu_cin   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_out   <= '0;
      r_rsp_odd   <= 1'b0;
      r_rsp_inv   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rsp_id <= w_grant;
        if (w_contested) r_ptr <= ~w_grant;
      end
      if (w_issue) begin
        r_alu_a   <= w_sel_a;
        r_alu_b   <= w_sel_b;
        r_alu_op  <= w_sel_op;
        r_alu_cin <= w_sel_cin;
      end
      if (r_state == S_EXEC) begin
        r_rsp_out   <= alu_Out;
        r_rsp_odd   <= alu_Oddparitty;
        r_rsp_inv   <= alu_Invalid;
        r_rsp_valid <= 1'b1;
`ifdef ALU_SHARE_OPCHECK_EN
      end else if (w_accept && w_illegal) begin
        r_rsp_out   <= '0;
        r_rsp_odd   <= 1'b0;
        r_rsp_inv   <= 1'b1;
        r_rsp_valid <= 1'b1;
`endif
      end else if (r_state == S_RESP && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_A          = r_alu_a;
  assign alu_B          = r_alu_b;
  assign alu_OP         = r_alu_op;
  assign alu_Cin        = r_alu_cin;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_id         = r_rsp_id;
  assign rsp_Out        = r_rsp_out;
  assign rsp_Oddparitty = r_rsp_odd;
  assign rsp_Invalid    = r_rsp_inv;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: drives a behavioural ALU plant and checks responses against a transaction-level model.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  localparam int W    = 8;
  localparam int PRIO = 0;

  typedef struct packed { logic [2*W-1:0] out; logic odd; logic inv; } res_t;
  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; logic [3:0] op; logic cin; } req_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  req_t p0, p1;
  logic [W-1:0] alu_A, alu_B;
  logic [3:0] alu_OP;
  logic alu_Cin;
  logic [2*W-1:0] alu_Out;
  logic alu_Oddparitty, alu_Invalid;
  logic rsp_valid, rsp_ready, rsp_id;
  logic [2*W-1:0] rsp_Out;
  logic rsp_Oddparitty, rsp_Invalid;

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr;
  req_t m_alu;

  always #5 clk = ~clk;

  alu_share_arbiter #(.Width(W), .Priority(PRIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_A(p0.a), .req0_B(p0.b), .req0_OP(p0.op), .req0_Cin(p0.cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_A(p1.a), .req1_B(p1.b), .req1_OP(p1.op), .req1_Cin(p1.cin),
    .alu_A(alu_A), .alu_B(alu_B), .alu_OP(alu_OP), .alu_Cin(alu_Cin),
    .alu_Out(alu_Out), .alu_Oddparitty(alu_Oddparitty), .alu_Invalid(alu_Invalid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_Out(rsp_Out), .rsp_Oddparitty(rsp_Oddparitty), .rsp_Invalid(rsp_Invalid)
  );

  // Behavioural ALU: and, or, add-with-carry, multiply, B-A, divide; other opcodes flag invalid.
  function automatic res_t alu_fn(req_t r);
    res_t x;
    x.inv = 1'b0;
    case (r.op)
      4'd0: x.out = {{W{1'b0}}, r.a & r.b};
      4'd1: x.out = {{W{1'b0}}, r.a | r.b};
      4'd2: x.out = (2*W)'(r.a) + (2*W)'(r.b) + (2*W)'(r.cin);
      4'd3: x.out = (2*W)'(r.a) * (2*W)'(r.b);
      4'd4: x.out = (2*W)'(r.b) - (2*W)'(r.a);
      4'd5: begin
        if (r.b == '0) begin x.out = (2*W)'(r.a); x.inv = 1'b1; end
        else x.out = (2*W)'(r.a / r.b);
      end
      default: begin x.out = {r.a, r.b}; x.inv = 1'b1; end
    endcase
    x.odd = ~(^x.out);
    return x;
  endfunction

  function automatic bit rejected(logic [3:0] op);
`ifdef ALU_SHARE_OPCHECK_EN
    return op >= 4'd6;
`else
    return 1'b0;
`endif
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.a   = W'($urandom);
    r.b   = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
    r.op  = 4'($urandom_range(0, 9));
    r.cin = 1'($urandom);
    return r;
  endfunction

  res_t plant;
  assign plant = alu_fn({alu_A, alu_B, alu_OP, alu_Cin});
  assign alu_Out = plant.out;
  assign alu_Oddparitty = plant.odd;
  assign alu_Invalid = plant.inv;

  // One transaction from the current request inputs; starts shortly after a rising edge with the DUT idle.
  task automatic do_op(input bit keep, input int delay);
    int win, exp_lat, lat;
    req_t wp;
    res_t exp;
    logic [1:0] exp_rdy;
    if (req0_valid && req1_valid) begin win = m_ptr; m_ptr = 1 - m_ptr; end
    else win = req1_valid ? 1 : 0;
    wp = (win == 1) ? p1 : p0;
    if (rejected(wp.op)) begin
      exp.out = '0; exp.odd = 1'b0; exp.inv = 1'b1; exp_lat = 1;
    end else begin
      exp = alu_fn(wp); exp_lat = 2; m_alu = wp;
    end
    exp_rdy = (win == 1) ? 2'b10 : 2'b01;
    rsp_ready = (delay == 0);
    @(negedge clk);
    n_checks++; if ({req1_ready, req0_ready} !== exp_rdy) begin n_errors++; $display("FAIL grant: ready=%b expected %b", {req1_ready, req0_ready}, exp_rdy); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL idle_rsp_valid: got %b expected 0", rsp_valid); end
    @(posedge clk); #1;
    if (!keep) begin if (win == 1) req1_valid = 1'b0; else req0_valid = 1'b0; end
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = c; break; end
      n_checks++; if ({req1_ready, req0_ready} !== 2'b00) begin n_errors++; $display("FAIL busy_ready: got %b expected 00", {req1_ready, req0_ready}); end
    end
    n_checks++; if (lat !== exp_lat) begin n_errors++; $display("FAIL latency: got %0d expected %0d (0 = timeout)", lat, exp_lat); end
    n_checks++; if (rsp_id !== 1'(win)) begin n_errors++; $display("FAIL rsp_id: got %0d expected %0d", rsp_id, win); end
    n_checks++; if ({rsp_Out, rsp_Oddparitty, rsp_Invalid} !== exp) begin n_errors++; $display("FAIL rsp_data: got out=%0h odd=%b inv=%b expected out=%0h odd=%b inv=%b", rsp_Out, rsp_Oddparitty, rsp_Invalid, exp.out, exp.odd, exp.inv); end
    n_checks++; if ({alu_A, alu_B, alu_OP, alu_Cin} !== m_alu) begin n_errors++; $display("FAIL alu_regs: got %0h expected %0h", {alu_A, alu_B, alu_OP, alu_Cin}, m_alu); end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1 || {req1_ready, req0_ready} !== 2'b00) begin n_errors++; $display("FAIL hold_ctrl: valid=%b ready=%b expected 1/00", rsp_valid, {req1_ready, req0_ready}); end
      n_checks++; if ({rsp_id, rsp_Out, rsp_Oddparitty, rsp_Invalid} !== {1'(win), exp}) begin n_errors++; $display("FAIL hold_data: got %0h expected %0h", {rsp_id, rsp_Out, rsp_Oddparitty, rsp_Invalid}, {1'(win), exp}); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    p0 = '0; p1 = '0; m_ptr = PRIO; m_alu = '0;
    repeat (2) @(negedge clk);
    n_checks++; if ({req1_ready, req0_ready} !== 2'b00) begin n_errors++; $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready}); end
    n_checks++; if ({rsp_valid, rsp_id, rsp_Out, rsp_Oddparitty, rsp_Invalid} !== '0) begin n_errors++; $display("FAIL reset_rsp: got %0h expected 0", {rsp_valid, rsp_id, rsp_Out, rsp_Oddparitty, rsp_Invalid}); end
    n_checks++; if ({alu_A, alu_B, alu_OP, alu_Cin} !== '0) begin n_errors++; $display("FAIL reset_alu: got %0h expected 0", {alu_A, alu_B, alu_OP, alu_Cin}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    p0 = '{a: 8'd12, b: 8'd5, op: 4'd2, cin: 1'b1};
    req0_valid = 1'b1;
    do_op(0, 0);
    n_checks++; if (rsp_Out !== 16'd18 || rsp_Oddparitty !== 1'b1 || rsp_Invalid !== 1'b0) begin n_errors++; $display("FAIL add_literal: got out=%0d odd=%b inv=%b expected 18/1/0", rsp_Out, rsp_Oddparitty, rsp_Invalid); end
  endtask

  task automatic test_contention();
    p0 = '{a: 8'd3, b: 8'd4, op: 4'd3, cin: 1'b0};
    p1 = '{a: 8'd2, b: 8'd9, op: 4'd4, cin: 1'b0};
    req0_valid = 1'b1; req1_valid = 1'b1;
    do_op(1, 0);
    n_checks++; if (rsp_id !== 1'b0 || rsp_Out !== 16'd12) begin n_errors++; $display("FAIL contention_first: got id=%0d out=%0d expected 0/12", rsp_id, rsp_Out); end
    do_op(1, 0);
    n_checks++; if (rsp_id !== 1'b1 || rsp_Out !== 16'd7) begin n_errors++; $display("FAIL contention_second: got id=%0d out=%0d expected 1/7", rsp_id, rsp_Out); end
    do_op(1, 0);
    do_op(1, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_div_zero();
    p1 = '{a: 8'd9, b: 8'd0, op: 4'd5, cin: 1'b0};
    req1_valid = 1'b1;
    do_op(0, 0);
    n_checks++; if (rsp_id !== 1'b1 || rsp_Out !== 16'd9 || rsp_Invalid !== 1'b1) begin n_errors++; $display("FAIL div_zero: got id=%0d out=%0d inv=%b expected 1/9/1", rsp_id, rsp_Out, rsp_Invalid); end
  endtask

  task automatic test_backpressure();
    p0 = rand_req(); p0.op = 4'd2;
    p1 = rand_req(); p1.op = 4'd3;
    req0_valid = 1'b1; req1_valid = 1'b1;
    do_op(1, 5);
    do_op(1, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    p0 = rand_req(); p0.op = 4'd1;
    p1 = rand_req(); p1.op = 4'd0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    do_op(0, 0);
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (req1_ready !== 1'b1) begin n_errors++; $display("FAIL midop_accept: got %b expected 1", req1_ready); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 1'b1;
    m_ptr = PRIO; m_alu = '0;
    #1;
    n_checks++; if ({rsp_valid, rsp_id, rsp_Out, rsp_Oddparitty, rsp_Invalid} !== '0) begin n_errors++; $display("FAIL midop_rsp: got %0h expected 0", {rsp_valid, rsp_id, rsp_Out, rsp_Oddparitty, rsp_Invalid}); end
    n_checks++; if ({alu_A, alu_B, alu_OP, alu_Cin} !== '0 || req0_ready !== 1'b0) begin n_errors++; $display("FAIL midop_alu: got %0h ready=%b expected 0/0", {alu_A, alu_B, alu_OP, alu_Cin}, req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL midop_no_rsp: got %b expected 0", rsp_valid); end
    end
    @(posedge clk); #1;
    p0 = rand_req(); p0.op = 4'd2;
    p1 = rand_req(); p1.op = 4'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    do_op(0, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_opcheck();
    p0 = '{a: 8'h21, b: 8'h43, op: 4'd6, cin: 1'b0};
    req0_valid = 1'b1;
    do_op(0, 0);
    n_checks++; if (rsp_Invalid !== 1'b1) begin n_errors++; $display("FAIL op6_invalid: got %b expected 1", rsp_Invalid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1) begin req0_valid = 1'b1; p0 = rand_req(); end
      if (!req1_valid && $urandom_range(0, 1) == 1) begin req1_valid = 1'b1; p1 = rand_req(); end
      if (!req0_valid && !req1_valid) begin req0_valid = 1'b1; p0 = rand_req(); end
      do_op(0, $urandom_range(0, 3));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_contention();
    test_div_zero();
    test_backpressure();
    test_reset_mid_op();
    test_opcheck();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
